c16_snd: RTL and testbench
==========================

# c16_snd

Multi-voice square-wave tone generator that consumes the sound-write port of the c16 CPU (`snd_wen`, `w_param`, `w_index`, `w_val`). It holds per-voice period, volume and control registers. At a fixed sample rate it advances each voice's phase, mixes the voices sequentially into one signed 16-bit sample, and emits it with a one-cycle valid strobe for the audio DAC/codec interface.

## Interface
- `NUM_VOICES`, default 4: voice count, power of two, 2..8.
- `TICK_DIV`, default 1000: clk cycles per sample tick. Must satisfy ≥ NUM_VOICES+2; violations are a parameter error.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `snd_wen` in 1: write strobe from the CPU, one cycle per write.
- `w_param` in 2: register select. 0 = period, 1 = volume, 2 = control, 3 = global.
- `w_index` in 11: voice number in low log2(NUM_VOICES) bits. Higher bits nonzero → write ignored. Ignored for global.
- `w_val` in 16: write data.
- `sample` out 16: signed mixed sample, held between strobes.
- `sample_valid` out 1: one-cycle strobe, `sample` new this cycle.

## Operation
- Per-voice registers:
  - period[15:0]: half-period in ticks.
  - volume[7:0]: from w_val[7:0].
  - ctrl: bit0 enable; bit1 phase-reset, self-clearing, not stored; bit2 noise select, see Configuration.
- Per-voice state: phase counter[15:0], level bit.
- Global register: bit0 mute.
- Write side:
  - A write updates the target register on the clock edge where `snd_wen`=1.
  - A phase-reset write clears the voice counter and level to 0 on that edge.
- Tick generator: counter 0..TICK_DIV-1. `tick` is asserted in the cycle the counter equals TICK_DIV-1, after which the counter wraps to 0.
- Phase update on tick, for each voice with enable=1 and period≠0:
  - If counter+1 ≥ period: counter←0 and level toggles.
  - Otherwise: counter←counter+1.
  - Period 0 or disabled: counter and level hold.
- Same-voice write and tick in the same cycle: the write wins for the register written. The phase update uses the pre-write period.
- Mixer FSM:
  - IDLE → MIX on tick.
  - MIX lasts NUM_VOICES cycles, visiting voice v in cycle v. acc (signed 16) += contribution: +volume if enabled and level=1, −volume if enabled and level=0, 0 if disabled or period=0. acc clears at MIX entry.
  - MIX → OUT. In OUT: sample ← mute ? 0 : acc <<< (7−log2 NUM_VOICES); sample_valid=1. Then → IDLE.
  - MIX reads the live registers. A write landing during MIX affects the voices not yet visited.
- Arithmetic: max |acc| = NUM_VOICES·255. The shift keeps `sample` within ±32640 with no saturation needed.
- Reset mid-operation: all registers, counters, LFSRs and acc return to reset values. FSM → IDLE. Any in-flight mix is discarded and no strobe is issued.

## Timing
- Reset values: sample=0, sample_valid=0, all voice registers 0, mute=0, tick counter 0, FSM IDLE.
- Register write takes effect on the next clock edge. It is audible at the first tick after the write.
- sample_valid asserts exactly NUM_VOICES+1 cycles after the tick cycle. It repeats every TICK_DIV cycles.
- No backpressure. The consumer must accept each strobe.

## Configuration
- `C16_SND_NOISE_EN` defined:
  - Each voice has a 15-bit LFSR, x^15+x^14+1, seeded 15'h0001 on reset and on phase-reset.
  - With ctrl bit2=1, a period expiry shifts the LFSR instead of toggling, and level = lfsr[0].
- Undefined:
  - No LFSR logic.
  - ctrl bit2 is accepted but ignored.
  - All voices are square-wave only.

## Structure
- Package `c16_snd_pkg`:
  - param codes P_PERIOD/P_VOLUME/P_CTRL/P_GLOBAL.
  - ctrl bit positions CTRL_EN/CTRL_PRST/CTRL_NOISE.
  - mixer state enum (S_IDLE, S_MIX, S_OUT).
  - LFSR seed constant.
- Sub-module `c16_snd_voice`, instantiated NUM_VOICES times. Contains the period/volume/ctrl registers, phase counter, level and optional LFSR. Outputs its signed contribution.
- Top contains: write decode, tick generator, mixer FSM, output registers.

## Test plan
- Reset → sample=0, sample_valid=0. First strobe at cycle TICK_DIV+NUM_VOICES (TICK_DIV=8, NUM_VOICES=4 → strobe at cycle 12 after reset release), with sample=0.
- Voice 0: period=2, volume=100, enable. All others off → samples −3200, +3200, +3200? No: level toggles every 2 ticks, so samples after enable are +3200,+3200,−3200,−3200,… starting from the first toggle (100·32=3200).
- All four voices: volume=255, period=1, enabled together → sample alternates +32640 / −32640 every tick, no overflow.
- Global mute=1 with voices active → sample=0 every strobe, strobe still every TICK_DIV cycles.
- Write with w_index=11'h004 (NUM_VOICES=4) → no register change. Mid-MIX volume write to voice 3 → the current sample already reflects the new volume.
- Noise (macro on): voice 0, ctrl=0x5, period=1 → level sequence follows LFSR from seed 0001. Assert reset mid-MIX → no strobe, sample=0.

Source files
------------

// File: rtl/c16_snd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : c16_snd_pkg                                                  |
// | Description : Shared codes, control-bit positions and mixer states for the |
// |               c16 square-wave tone generator.                              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package c16_snd_pkg;

    localparam logic [1:0] P_PERIOD = 2'd0;
    localparam logic [1:0] P_VOLUME = 2'd1;
    localparam logic [1:0] P_CTRL   = 2'd2;
    localparam logic [1:0] P_GLOBAL = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_PRST  = 1;
    localparam int CTRL_NOISE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_OUT  = 2'd2
    } mix_state_e;

    localparam logic [14:0] LFSR_SEED = 15'h0001;

endpackage
`default_nettype wire

// File: rtl/c16_snd_voice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : c16_snd_voice                                                |
// | Description : One tone voice: period/volume/ctrl registers, phase counter, |
// |               level bit and signed mixer contribution. The LFSR noise      |
// |               source exists only when C16_SND_NOISE_EN is defined.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module c16_snd_voice
    import c16_snd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_i,
    input  logic               we_i,
    input  logic [1:0]         param_i,
    input  logic [15:0]        val_i,
    output logic signed [15:0] contrib_o
);

    logic [15:0] period_q, period_d;
    logic [7:0]  volume_q, volume_d;
    logic        en_q,     en_d;
    logic [15:0] cnt_q,    cnt_d;
    logic        level_q,  level_d;
    logic        expire;
`ifdef C16_SND_NOISE_EN
    logic        noise_q,  noise_d;
    logic [14:0] lfsr_q,   lfsr_d;
`endif

    // Widened compare so counter+1 cannot wrap at 16'hFFFF.
    assign expire = ({1'b0, cnt_q} + 17'd1) >= {1'b0, period_q};

    always_comb begin
        period_d = period_q;
        volume_d = volume_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
`ifdef C16_SND_NOISE_EN
        noise_d  = noise_q;
        lfsr_d   = lfsr_q;
`endif
        if (tick_i && en_q && (period_q != 16'd0)) begin
            if (expire) begin
                cnt_d = 16'd0;
`ifdef C16_SND_NOISE_EN
                if (noise_q) begin
                    lfsr_d  = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                    level_d = lfsr_q[14] ^ lfsr_q[13];
                end else begin
                    level_d = ~level_q;
                end
`else
                level_d = ~level_q;
`endif
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        // Applied after the phase update so a same-cycle write wins.
        if (we_i) begin
            case (param_i)
                P_PERIOD: period_d = val_i;
                P_VOLUME: volume_d = val_i[7:0];
                P_CTRL: begin
                    en_d = val_i[CTRL_EN];
`ifdef C16_SND_NOISE_EN
                    noise_d = val_i[CTRL_NOISE];
`endif
                    if (val_i[CTRL_PRST]) begin
                        cnt_d   = 16'd0;
                        level_d = 1'b0;
`ifdef C16_SND_NOISE_EN
                        lfsr_d  = LFSR_SEED;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= 16'd0;
            volume_q <= 8'd0;
            en_q     <= 1'b0;
            cnt_q    <= 16'd0;
            level_q  <= 1'b0;
`ifdef C16_SND_NOISE_EN
            noise_q  <= 1'b0;
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            period_q <= period_d;
            volume_q <= volume_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
`ifdef C16_SND_NOISE_EN
            noise_q  <= noise_d;
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    always_comb begin
        contrib_o = 16'sd0;
        if (en_q && (period_q != 16'd0)) begin
            contrib_o = level_q ? $signed({8'd0, volume_q}) : -$signed({8'd0, volume_q});
        end
    end

endmodule
`default_nettype wire

// File: rtl/c16_snd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : c16_snd                                                      |
// | Description : Multi-voice tone generator: CPU write decode, sample tick,   |
// |               sequential mixer and output sample/strobe registers.         |
// |               Optional noise voices via C16_SND_NOISE_EN.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module c16_snd
    import c16_snd_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int TICK_DIV   = 1000
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               snd_wen,
    input  logic [1:0]         w_param,
    input  logic [10:0]        w_index,
    input  logic [15:0]        w_val,
    output logic signed [15:0] sample,
    output logic               sample_valid
);

    localparam int C_VW    = $clog2(NUM_VOICES);
    localparam int C_TW    = $clog2(TICK_DIV);
    localparam int C_SHIFT = 7 - C_VW;
    localparam logic [C_TW-1:0] C_TICK_LAST  = C_TW'(TICK_DIV - 1);
    localparam logic [C_VW-1:0] C_VOICE_LAST = C_VW'(NUM_VOICES - 1);

    generate
        if ((NUM_VOICES < 2) || (NUM_VOICES > 8) ||
            ((NUM_VOICES & (NUM_VOICES - 1)) != 0)) begin : g_bad_voices
            $error("c16_snd: NUM_VOICES must be a power of two in 2..8");
        end
        if (TICK_DIV < NUM_VOICES + 2) begin : g_bad_div
            $error("c16_snd: TICK_DIV must be at least NUM_VOICES+2");
        end
    endgenerate

    logic                  tick;
    logic                  idx_ok;
    logic [NUM_VOICES-1:0] voice_we;
    logic signed [15:0]    contrib [NUM_VOICES];

    logic [C_TW-1:0]    tick_cnt_q;
    mix_state_e         state_q,  state_d;
    logic [C_VW-1:0]    vidx_q,   vidx_d;
    logic signed [15:0] acc_q,    acc_d;
    logic signed [15:0] acc_sum;
    logic               mute_q,   mute_d;
    logic signed [15:0] sample_q, sample_d;
    logic               valid_q,  valid_d;

    assign idx_ok = (w_index[10:C_VW] == '0);

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            assign voice_we[v] = snd_wen && (w_param != P_GLOBAL) && idx_ok &&
                                 (w_index[C_VW-1:0] == C_VW'(v));

            c16_snd_voice u_voice (
                .clk       (clk),
                .reset     (reset),
                .tick_i    (tick),
                .we_i      (voice_we[v]),
                .param_i   (w_param),
                .val_i     (w_val),
                .contrib_o (contrib[v])
            );
        end
    endgenerate

    assign tick = (tick_cnt_q == C_TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + C_TW'(1);
        end
    end

    // Voices are read live, so a write during MIX reaches voices not yet visited.
    assign acc_sum = acc_q + contrib[vidx_q];

    always_comb begin
        state_d  = state_q;
        vidx_d   = vidx_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        mute_d   = (snd_wen && (w_param == P_GLOBAL)) ? w_val[0] : mute_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_MIX;
                    vidx_d  = '0;
                    acc_d   = 16'sd0;
                end
            end
            S_MIX: begin
                acc_d  = acc_sum;
                vidx_d = vidx_q + C_VW'(1);
                // Output registers load on this edge so the strobe and data coincide in OUT.
                if (vidx_q == C_VOICE_LAST) begin
                    state_d  = S_OUT;
                    sample_d = mute_q ? 16'sd0 : (acc_sum <<< C_SHIFT);
                    valid_d  = 1'b1;
                end
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vidx_q   <= '0;
            acc_q    <= 16'sd0;
            mute_q   <= 1'b0;
            sample_q <= 16'sd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vidx_q   <= vidx_d;
            acc_q    <= acc_d;
            mute_q   <= mute_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_c16_snd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_c16_snd                                                   |
// | Description : Self-checking bench for c16_snd against a behavioural model. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_c16_snd;

    localparam int NV = 4;
    localparam int TD = 8;
    localparam int SCALE = 1 << (7 - $clog2(NV));

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               snd_wen = 1'b0;
    logic [1:0]         w_param = 2'd0;
    logic [10:0]        w_index = 11'd0;
    logic [15:0]        w_val = 16'd0;
    logic signed [15:0] sample;
    logic               sample_valid;

    always #5 clk = ~clk;

    c16_snd #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .snd_wen      (snd_wen),
        .w_param      (w_param),
        .w_index      (w_index),
        .w_val        (w_val),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: voice registers and state, plus mixer progress.
    int m_period [NV];
    int m_volume [NV];
    int m_cnt    [NV];
    int m_lfsr   [NV];
    bit m_en     [NV];
    bit m_level  [NV];
    bit m_noise  [NV];
    bit m_mute;
    int m_tc;
    int m_phase;      // 0 idle, 1..NV visiting voice phase-1, NV+1 strobe
    int m_acc;
    int exp_sample;
    bit exp_valid;
    int cyc;

    function automatic int contrib(int v);
        if (!m_en[v] || m_period[v] == 0) return 0;
        return m_level[v] ? m_volume[v] : -m_volume[v];
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NV; k++) begin
            m_period[k] = 0; m_volume[k] = 0; m_cnt[k] = 0; m_lfsr[k] = 1;
            m_en[k] = 0; m_level[k] = 0; m_noise[k] = 0;
        end
        m_mute = 0; m_tc = 0; m_phase = 0; m_acc = 0;
        exp_sample = 0; exp_valid = 0; cyc = 0;
    endtask

    // One clock: drive inputs, advance the model over the edge, settle.
    task automatic step(input bit we, input int p, input int idx, input int v);
        bit tick_now;
        int fb;
        snd_wen = we; w_param = 2'(p); w_index = 11'(idx); w_val = 16'(v);
        tick_now = (m_tc == TD - 1);
        @(posedge clk);
        if (m_phase == 0) begin
            if (tick_now) begin m_phase = 1; m_acc = 0; end
        end else if (m_phase <= NV) begin
            m_acc += contrib(m_phase - 1);
            m_phase++;
            if (m_phase == NV + 1) exp_sample = m_mute ? 0 : m_acc * SCALE;
        end else begin
            m_phase = 0;
        end
        if (tick_now) begin
            for (int k = 0; k < NV; k++) begin
                if (m_en[k] && m_period[k] != 0) begin
                    if (m_cnt[k] + 1 >= m_period[k]) begin
                        m_cnt[k] = 0;
`ifdef C16_SND_NOISE_EN
                        if (m_noise[k]) begin
                            fb = ((m_lfsr[k] >> 14) ^ (m_lfsr[k] >> 13)) & 1;
                            m_lfsr[k]  = ((m_lfsr[k] << 1) | fb) & 'h7fff;
                            m_level[k] = fb[0];
                        end else
`endif
                        m_level[k] = !m_level[k];
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
        end
        if (we) begin
            if (p == 3) m_mute = v[0];
            else if (idx >= 0 && idx < NV) begin
                case (p)
                    0: m_period[idx] = v & 'hffff;
                    1: m_volume[idx] = v & 'hff;
                    default: begin
                        m_en[idx]    = v[0];
                        m_noise[idx] = v[2];
                        if (v[1]) begin m_cnt[idx] = 0; m_level[idx] = 0; m_lfsr[idx] = 1; end
                    end
                endcase
            end
        end
        m_tc = (m_tc == TD - 1) ? 0 : m_tc + 1;
        exp_valid = (m_phase == NV + 1);
        cyc++;
        #1;
        snd_wen = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; snd_wen = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        #1;
        total++;
        if (sample_valid !== 1'b0 || sample !== 16'sd0) begin
            bad++;
            $display("FAIL reset_values valid=%0b sample=%0d required valid=0 sample=0", sample_valid, sample);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int first = -1;
        apply_reset(3);
        for (int i = 0; i < 3 * TD; i++) begin
            step(0, 0, 0, 0);
            if (sample_valid === 1'b1 && first < 0) first = cyc;
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL reset_run cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
        end
        total++;
        if (first != TD + NV) begin
            bad++;
            $display("FAIL first_strobe cycle=%0d required %0d", first, TD + NV);
        end
    endtask

    task automatic test_square();
        step(1, 0, 0, 2);
        step(1, 1, 0, 100);
        step(1, 2, 0, 1);
        for (int i = 0; i < 8 * TD; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL square cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
            if (i >= 2 * TD && sample_valid === 1'b1) begin
                total++;
                if (iabs(int'(sample)) != 3200) begin
                    bad++;
                    $display("FAIL square_level sample=%0d required +/-3200", sample);
                end
            end
        end
    endtask

    task automatic test_full_scale();
        apply_reset(2);
        for (int k = 0; k < NV; k++) begin
            step(1, 1, k, 255);
            step(1, 0, k, 1);
        end
        for (int i = 0; i < 2 * TD && m_tc != 0; i++) step(0, 0, 0, 0);
        for (int k = 0; k < NV; k++) step(1, 2, k, 3);
        for (int i = 0; i < 8 * TD; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL full_scale cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
            if (i >= 2 * TD && sample_valid === 1'b1) begin
                total++;
                if (iabs(int'(sample)) != 32640) begin
                    bad++;
                    $display("FAIL full_scale_mag sample=%0d required +/-32640", sample);
                end
            end
        end
    endtask

    task automatic test_mute();
        int strobes = 0;
        step(1, 3, 0, 1);
        for (int i = 0; i < 2 * TD; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4 * TD; i++) begin
            step(0, 0, 0, 0);
            if (sample_valid === 1'b1) strobes++;
            total++;
            if (sample_valid !== exp_valid || sample !== 16'sd0) begin
                bad++;
                $display("FAIL mute cyc=%0d valid=%0b sample=%0d required valid=%0b sample=0",
                         cyc, sample_valid, sample, exp_valid);
            end
        end
        total++;
        if (strobes != 4) begin
            bad++;
            $display("FAIL mute_rate strobes=%0d required 4", strobes);
        end
        step(1, 3, 0, 0);
    endtask

    task automatic test_bad_index();
        step(1, 1, 11'h004, 1);
        step(1, 2, 11'h404, 0);
        step(1, 0, 11'h7fc, 0);
        for (int i = 0; i < 4 * TD; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL bad_index cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
            if (i >= 2 * TD && sample_valid === 1'b1) begin
                total++;
                if (iabs(int'(sample)) != 32640) begin
                    bad++;
                    $display("FAIL bad_index_mag sample=%0d required +/-32640", sample);
                end
            end
        end
    endtask

    task automatic test_mid_mix();
        bit seen = 0;
        for (int i = 0; i < 2 * TD && m_phase != 1; i++) step(0, 0, 0, 0);
        step(1, 1, 3, 10);
        for (int i = 0; i < 2 * TD && !seen; i++) begin
            step(0, 0, 0, 0);
            if (exp_valid) begin
                seen = 1;
                total++;
                if (sample_valid !== 1'b1 || iabs(int'(sample)) != (3 * 255 + 10) * SCALE ||
                    sample !== 16'(exp_sample)) begin
                    bad++;
                    $display("FAIL mid_mix valid=%0b sample=%0d required valid=1 sample=%0d",
                             sample_valid, sample, exp_sample);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_mix_timeout no strobe within %0d cycles", 2 * TD);
        end
    endtask

    task automatic test_reset_mid_mix();
        for (int i = 0; i < 2 * TD && m_phase != 2; i++) step(0, 0, 0, 0);
        total++;
        if (m_phase != 2 || sample === 16'sd0) begin
            bad++;
            $display("FAIL mid_mix_setup phase=%0d sample=%0d required phase=2 sample!=0", m_phase, sample);
        end
        apply_reset(1);
        for (int i = 0; i < 2 * TD + NV; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL reset_mid_mix cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
        end
    endtask

`ifdef C16_SND_NOISE_EN
    task automatic test_noise();
        apply_reset(2);
        step(1, 1, 0, 100);
        step(1, 0, 0, 1);
        step(1, 2, 0, 5);
        for (int i = 0; i < 12 * TD; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL noise cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
        end
    endtask
`endif

    task automatic test_random();
        int p, idx, v;
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            p   = $urandom_range(0, 3);
            idx = $urandom_range(0, 5);
            case (p)
                0:       v = $urandom_range(0, 4);
                1:       v = $urandom_range(0, 255);
                2:       v = $urandom_range(0, 7);
                default: v = ($urandom_range(0, 7) == 0) ? 1 : 0;
            endcase
            step($urandom_range(0, 2) == 0, p, idx, v);
            total++;
            if (sample_valid !== exp_valid || sample !== 16'(exp_sample)) begin
                bad++;
                $display("FAIL random cyc=%0d valid=%0b sample=%0d required valid=%0b sample=%0d",
                         cyc, sample_valid, sample, exp_valid, exp_sample);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_square();
        test_full_scale();
        test_mute();
        test_bad_index();
        test_mid_mix();
        test_reset_mid_mix();
`ifdef C16_SND_NOISE_EN
        test_noise();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
